// File: rtl/bitstream_self_writer_if.sv
// Byte-stream input and self-write output bundle for bitstream_self_writer.
// The slave modport is the writer itself; the master modport is the byte feeder.
interface bitstream_self_writer_if;
  logic        start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic [31:0] SelfWriteData;
  logic        SelfWriteStrobe;
  logic        busy;
  logic        done;
  logic [12:0] word_count;

  modport master (
    output start, byte_data, byte_valid, byte_last,
    input  byte_ready, SelfWriteData, SelfWriteStrobe, busy, done, word_count
  );

  modport slave (
    input  start, byte_data, byte_valid, byte_last,
    output byte_ready, SelfWriteData, SelfWriteStrobe, busy, done, word_count
  );
endinterface

// File: rtl/bitstream_self_writer.sv
// Packs a byte stream big-endian into 32-bit words and drives each word to the
// fabric self-write port with fixed setup / one-cycle strobe / hold timing.
module bitstream_self_writer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned MAX_BYTES    = 16384
) (
  input  logic                    CLK,
  input  logic                    resetn,
  bitstream_self_writer_if.slave  bus
);

  localparam logic [12:0] MAX_WORDS = 13'(MAX_BYTES / 4);
  localparam logic [3:0]  SETUP_END = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0]  HOLD_END  = 4'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, SETUP, STROBE, HOLD, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] data_q, data_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] wc_q, wc_d;
  logic        ready_q, ready_d;
  logic        strobe_q, strobe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic [31:0] byte_word;

  // Shift buffer only ever holds already-placed bytes, so unfilled lanes stay zero.
  assign accept    = ready_q & bus.byte_valid;
  assign byte_word = {bus.byte_data, 24'h000000} >> {idx_q, 3'b000};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = COLLECT;
          idx_d   = '0;
          shift_d = '0;
          wc_d    = '0;
          last_d  = 1'b0;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (idx_q == 2'd3 || bus.byte_last) begin
            data_d  = shift_q | byte_word;
            shift_d = '0;
            idx_d   = '0;
            last_d  = bus.byte_last;
            cnt_d   = '0;
            state_d = SETUP;
          end else begin
            shift_d = shift_q | byte_word;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_END) state_d = STROBE;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      STROBE: begin
        wc_d    = wc_q + 13'd1;
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == HOLD_END) state_d = (last_q || wc_q == MAX_WORDS) ? DONE : COLLECT;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_d  = (state_d == COLLECT);
    strobe_d = (state_d == STROBE);
    busy_d   = (state_d == COLLECT) || (state_d == SETUP) ||
               (state_d == STROBE)  || (state_d == HOLD);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      wc_q     <= '0;
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wc_q     <= wc_d;
      ready_q  <= ready_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.byte_ready      = ready_q;
  assign bus.SelfWriteData   = data_q;
  assign bus.SelfWriteStrobe = strobe_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.word_count      = wc_q;

endmodule

// File: tb/tb_bitstream_self_writer.sv
// Randomized self-checking bench for bitstream_self_writer: one default-sized
// instance and one with a 16-byte limit, driven one at a time from shared stimulus.
module tb_bitstream_self_writer;

  localparam int SETUP = 2;
  localparam int HOLD  = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  bitstream_self_writer_if ifa ();
  bitstream_self_writer_if ifb ();

  bitstream_self_writer #(.SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .MAX_BYTES(16384)) dut_a (
    .CLK(clk), .resetn(resetn), .bus(ifa)
  );
  bitstream_self_writer #(.SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .MAX_BYTES(16)) dut_b (
    .CLK(clk), .resetn(resetn), .bus(ifb)
  );

  bit         sel;
  logic       drv_start, drv_valid, drv_last;
  logic [7:0] drv_data;

  assign ifa.start      = drv_start & ~sel;
  assign ifa.byte_valid = drv_valid & ~sel;
  assign ifa.byte_data  = drv_data;
  assign ifa.byte_last  = drv_last;
  assign ifb.start      = drv_start & sel;
  assign ifb.byte_valid = drv_valid & sel;
  assign ifb.byte_data  = drv_data;
  assign ifb.byte_last  = drv_last;

  logic        m_ready, m_strobe, m_busy, m_done;
  logic [31:0] m_data;
  logic [12:0] m_wc;
  assign m_ready  = sel ? ifb.byte_ready      : ifa.byte_ready;
  assign m_strobe = sel ? ifb.SelfWriteStrobe : ifa.SelfWriteStrobe;
  assign m_busy   = sel ? ifb.busy            : ifa.busy;
  assign m_done   = sel ? ifb.done            : ifa.done;
  assign m_data   = sel ? ifb.SelfWriteData   : ifa.SelfWriteData;
  assign m_wc     = sel ? ifb.word_count      : ifa.word_count;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  tx[0:31];
  logic [31:0] exp_q[$];

  // Monitor state
  int          cyc = 0, stb_cnt = 0, acc_cnt = 0, hold_left = 0;
  int          last_acc = 0, last_stb = 0, last_gap = 0;
  logic [31:0] prev_data = '0, hold_word = '0;
  logic        prev_strobe = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      hold_left = 0;
    end else begin
      if (drv_start) begin
        stb_cnt = 0; acc_cnt = 0; hold_left = 0;
      end
      if (drv_valid && m_ready) begin
        acc_cnt++;
        last_acc = cyc;
      end
      if (m_strobe) begin
        if (stb_cnt < exp_q.size()) check("stb_word", m_data, exp_q[stb_cnt]);
        else                        check("extra_strobe", stb_cnt, exp_q.size());
        check("stb_after_accept", cyc - last_acc, SETUP + 1);
        check("setup_stable", {prev_strobe, prev_data}, {1'b0, m_data});
        hold_word = m_data;
        last_gap  = cyc - last_stb;
        last_stb  = cyc;
        stb_cnt++;
        hold_left = HOLD;
      end else if (hold_left > 0) begin
        check("hold_data", {m_strobe, m_data}, {1'b0, hold_word});
        if (hold_left == HOLD) check("wc_after_strobe", m_wc, stb_cnt);
        hold_left--;
      end
      if (m_done && !prev_done) check("done_timing", cyc - last_stb, HOLD + 1);
    end
    prev_data   = m_data;
    prev_strobe = m_strobe;
    prev_done   = m_done;
  end

  task automatic pulse_start();
    drv_start = 1'b1;
    @(posedge clk); #1;
    drv_start = 1'b0;
    @(negedge clk);
    check("start_state", {m_ready, m_busy, m_done, m_wc}, {3'b110, 13'd0});
    @(posedge clk); #1;
  endtask

  task automatic feed(input int n, input bit use_last, input int gmin, input int gmax);
    bit got;
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(gmax, gmin);
      repeat (g) begin @(posedge clk); #1; end
      drv_data  = tx[i];
      drv_last  = use_last && (i == n - 1);
      drv_valid = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
        @(negedge clk);
        got = m_ready;
        @(posedge clk); #1;
      end
      drv_valid = 1'b0;
      drv_last  = 1'b0;
      if (!got) break;
    end
  endtask

  // Reference: chunk the accepted prefix into big-endian words, zero-filling the tail.
  task automatic run_load(input int n, input bit use_last, input int gmin, input int gmax);
    int limit, eff, nw;
    bit exp_done;
    logic [31:0] w;
    limit    = sel ? 16 : 16384;
    eff      = (n < limit) ? n : limit;
    nw       = (eff + 3) / 4;
    exp_done = use_last || (n >= limit);
    exp_q.delete();
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) w = {w[23:0], (4*k + j < eff) ? tx[4*k + j] : 8'h00};
      exp_q.push_back(w);
    end
    pulse_start();
    feed(n, use_last, gmin, gmax);
    @(negedge clk);
    check("ready_after_word", m_ready, 1'b0);
    @(posedge clk); #1;
    if (exp_done) begin
      for (int t = 0; t < 60 && !m_done; t++) begin @(posedge clk); #1; end
    end else begin
      repeat (8) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    check("accepted_bytes", acc_cnt, eff);
    check("strobe_count", stb_cnt, nw);
    check("word_count_end", m_wc, nw);
    check("end_flags", {m_done, m_busy, m_ready}, exp_done ? 3'b100 : 3'b011);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic set_tx(input logic [63:0] b8);
    logic [63:0] v;
    v = b8;
    for (int i = 0; i < 8; i++) tx[i] = v[63 - 8*i -: 8];
  endtask

  initial begin
    int n;
    sel = 1'b0;
    drv_start = 1'b0; drv_valid = 1'b0; drv_last = 1'b0; drv_data = '0;
    resetn = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("reset_a", {ifa.byte_ready, ifa.SelfWriteStrobe, ifa.busy, ifa.done, ifa.word_count, ifa.SelfWriteData}, '0);
    check("reset_b", {ifb.byte_ready, ifb.SelfWriteStrobe, ifb.busy, ifb.done, ifb.word_count, ifb.SelfWriteData}, '0);
    resetn = 1'b1;
    @(posedge clk); #1;

    set_tx(64'h12345678_00000000);
    run_load(4, 1'b0, 0, 0);
    do_reset();

    set_tx(64'hAABBCCDD_01020304);
    run_load(8, 1'b1, 0, 0);
    check("strobe_spacing", last_gap, 4 + SETUP + 1 + HOLD);

    set_tx(64'h11223344_55000000);
    run_load(5, 1'b1, 0, 0);

    set_tx(64'hAABBCCDD_01020304);
    run_load(8, 1'b1, 3, 3);

    // Reset while word 3 is in its setup window.
    for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
    exp_q.delete();
    exp_q.push_back({tx[0], tx[1], tx[2], tx[3]});
    exp_q.push_back({tx[4], tx[5], tx[6], tx[7]});
    pulse_start();
    feed(12, 1'b0, 0, 0);
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_mid_load", {m_ready, m_strobe, m_busy, m_done, m_wc, m_data}, '0);
    resetn = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("no_strobe_word3", stb_cnt, 2);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
      run_load(n, 1'b1, 0, 2);
    end

    sel = 1'b1;
    for (int i = 0; i < 20; i++) tx[i] = 8'($urandom);
    run_load(20, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) tx[i] = 8'($urandom);
    run_load(6, 1'b1, 0, 1);
    for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
    run_load(16, 1'b0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
